// File: rtl/dram_cmd_queue.sv
// DRAM command queue: buffers client read/write commands in a small FIFO
// and issues them one at a time to the DRAM controller over ena/ack/busy.
module dram_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int AW          = 24,
  parameter int DW          = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic [AW-1:0] ctl_addr,
  output logic          ctl_write,
  output logic          ctl_ena,
  output logic [DW-1:0] ctl_wr_data,
  input  logic          ctl_ack,
  input  logic          ctl_busy,
  input  logic [DW-1:0] ctl_rd_data,
  output logic          idle,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   PTR_ONE    = (PW+1)'(1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

  logic [AW-1:0] q_addr  [DEPTH];
  logic          q_write [DEPTH];
  logic [DW-1:0] q_wdata [DEPTH];

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [TW-1:0] tmo_cnt;

  // Occupancy and handshake qualifiers derived from the pointers.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full  = (count == FULL_COUNT);
    empty = (count == '0);
    push  = cmd_valid & ~full;
    pop   = (state == S_IDLE) & ~empty & ~ctl_busy;
  end

  assign cmd_ready = ~full;
  assign idle      = empty & (state == S_IDLE);

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr[PW-1:0]]  <= cmd_addr;
      q_write[wr_ptr[PW-1:0]] <= cmd_write;
      q_wdata[wr_ptr[PW-1:0]] <= cmd_wdata;
    end
  end

  // FIFO pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Issue sequencer: IDLE -> REQ -> WAIT -> DONE with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ctl_ena     <= 1'b0;
      ctl_write   <= 1'b0;
      ctl_addr    <= '0;
      ctl_wr_data <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      err         <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            ctl_addr    <= q_addr[rd_ptr[PW-1:0]];
            ctl_write   <= q_write[rd_ptr[PW-1:0]];
            ctl_wr_data <= q_wdata[rd_ptr[PW-1:0]];
            ctl_ena     <= 1'b1;
            tmo_cnt     <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (ctl_ack) begin
            ctl_ena <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            ctl_ena <= 1'b0;
            err     <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        S_WAIT: begin
          // Read data is captured on the edge leaving WAIT so the registered
          // strobe is high exactly while the FSM sits in DONE.
          if (!ctl_busy) begin
            state <= S_DONE;
            if (!ctl_write) begin
              rsp_valid <= 1'b1;
              rsp_data  <= ctl_rd_data;
              rsp_addr  <= ctl_addr;
            end
          end
        end
        S_DONE: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          ctl_ena   <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_cmd_queue.md
Name: dram_cmd_queue

Overview:
Command buffer and handshake sequencer between any DRAM client (test sequencer, loader) and the DRAM controller. Accepts read/write commands on a valid/ready port and queues them in a small FIFO. Issues each command to the controller with the ena/ack/busy protocol, holding address, write flag and write data stable for the whole transaction. Returns read data on a one-cycle response strobe and flags a sticky error if the controller never acknowledges.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 24, address width
DW, 8, data width
ACK_TIMEOUT, 1024, cycles allowed in REQ without ctl_ack before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  queue can accept; equals !full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  command address
cmd_wdata  in  DW  write data; ignored for reads
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_data  out  DW  read data, valid with rsp_valid
rsp_addr  out  AW  address of the returned read
ctl_addr  out  AW  to controller addr
ctl_write  out  1  to controller write
ctl_ena  out  1  to controller ena
ctl_wr_data  out  DW  to controller write data
ctl_ack  in  1  controller accepted request
ctl_busy  in  1  controller busy (access or refresh)
ctl_rd_data  in  DW  controller read data
idle  out  1  FIFO empty and FSM in IDLE
err  out  1  sticky ack-timeout flag

Behaviour:
- Reset (async, immediate): FIFO empty, FSM IDLE, ctl_ena=0, ctl_write=0, ctl_addr=0, ctl_wr_data=0, rsp_valid=0, rsp_data=0, rsp_addr=0, err=0, timeout counter=0. cmd_ready=1 and idle=1 after reset. Reset mid-transaction drops ctl_ena immediately and discards queued commands.
- FIFO: push on cmd_valid & cmd_ready. Pop on the IDLE->REQ transition. Simultaneous push and pop when full: push refused because cmd_ready=0 that cycle. Simultaneous push and pop when empty: not possible, since pop requires non-empty. Pointers are log2(DEPTH)+1 bits and wrap naturally. cmd_ready is registered-free (comb from count).
- FSM states:
  - IDLE: if FIFO non-empty and !ctl_busy, load the head entry into ctl_addr/ctl_write/ctl_wr_data, pop, go to REQ. While ctl_busy is high (refresh), hold IDLE.
  - REQ: ctl_ena=1. Timeout counter increments each cycle. When ctl_ack=1, go to WAIT and clear the counter. If the counter reaches ACK_TIMEOUT-1 without ack, set err=1, drop ena, and go to IDLE; the command is dropped.
  - WAIT: ctl_ena=0. When !ctl_busy, go to DONE.
  - DONE: if !ctl_write, rsp_valid=1 for exactly this cycle, with rsp_data=ctl_rd_data and rsp_addr=ctl_addr captured. Go to IDLE.
- ctl_addr, ctl_write and ctl_wr_data change only on the IDLE->REQ transition. They are stable through REQ, WAIT and DONE.
- Minimum 4 cycles per command (IDLE, REQ, WAIT, DONE) plus controller latency. Back-to-back commands reissue on the cycle after DONE if !ctl_busy.
- ctl_ack while not in REQ: ignored.
- err clears only on rst.
- idle = FIFO empty & state==IDLE.
- Reads and writes complete strictly in FIFO order. A read after a write to the same address returns the written data, given a correct controller.

Test Plan:
- Reset then single write (addr 0x000010, data 0xA5), controller acks in 2 cycles and drops busy 5 cycles later. Required: ctl_ena high exactly until the ack cycle, ctl_addr=0x000010 and ctl_wr_data=0xA5 stable throughout, no rsp_valid, idle returns to 1.
- Read of 0x000010 with controller returning 0xA5. Required: exactly one rsp_valid pulse with rsp_data=0xA5 and rsp_addr=0x000010.
- Push 5 commands back-to-back with the controller stalled (busy=1). Required: cmd_ready falls after the 4th push, the 5th is held; after busy releases, all execute in push order.
- Hold ctl_busy=1 for 50 cycles (refresh) with the FIFO non-empty. Required: ctl_ena stays 0 until busy falls, then the request issues next cycle.
- Never assert ctl_ack, with ACK_TIMEOUT=16. Required: ctl_ena drops after 16 REQ cycles, err=1 and stays set, and the next queued command proceeds.
- Assert rst while in WAIT with 2 commands queued. Required: ctl_ena=0, idle=1, cmd_ready=1 immediately, no rsp_valid afterwards.
